// File: rtl/pbs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : pbs_pkg                                                     |
// | Brief  : Move table, PP default, LFSR constants and FSM state type   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package pbs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROLL   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  localparam int unsigned c_pp_init_dflt = 5;
  localparam int unsigned c_tab_entries  = 4;

  localparam logic [15:0] c_lfsr_seed = 16'hACE1;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: bits 0,2,3,5 feed bit 15
  localparam logic [15:0] c_lfsr_taps = 16'h002D;

  localparam logic [3:0][7:0] c_move_dmg = {8'd11, 8'd5, 8'd3, 8'd1};
  localparam logic [3:0][7:0] c_move_acc = {8'd3,  8'd7, 8'd8, 8'd10};

  function automatic logic [7:0] move_dmg(input int unsigned idx);
    logic [7:0] v;
    v = 8'd0;
    if (idx < c_tab_entries) v = c_move_dmg[idx[1:0]];
    return v;
  endfunction

  function automatic logic [7:0] move_acc(input int unsigned idx);
    logic [7:0] v;
    v = 8'd0;
    if (idx < c_tab_entries) v = c_move_acc[idx[1:0]];
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pbs_lfsr16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : pbs_lfsr16                                                  |
// | Brief  : Free-running 16-bit Fibonacci LFSR, never all-zero          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module pbs_lfsr16
  import pbs_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] value
);

  logic [15:0] r_lfsr;
  logic [15:0] w_next;
  logic        w_fb;

  always_comb begin
    w_fb   = ^(r_lfsr & c_lfsr_taps);
    w_next = {w_fb, r_lfsr[15:1]};
    // Lock-up guard: the zero state can only arise from corruption, reseed
    if (w_next == 16'h0000) w_next = c_lfsr_seed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= c_lfsr_seed;
    else        r_lfsr <= w_next;
  end

  assign value = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/move_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : move_resolver                                               |
// | Brief  : Accepts a move, rolls accuracy, tracks PP, returns result   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module move_resolver
  import pbs_pkg::*;
#(
  parameter int unsigned NUM_MOVES = 4,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned DMG_W     = 4,
  parameter int unsigned ACC_W     = 4,
  parameter int unsigned PP_W      = 3,
  parameter int unsigned PP_INIT   = c_pp_init_dflt
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_move,
  output logic             req_ready,
  input  logic             pp_refill,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_hit,
  output logic [DMG_W-1:0] res_dmg,
  output logic             res_no_pp,
  output logic             res_illegal
);

  localparam logic [PP_W-1:0]  c_pp_init     = PP_W'(PP_INIT);
  localparam logic [PP_W-1:0]  c_pp_init_m1  = (PP_INIT == 0) ? '0 : PP_W'(PP_INIT - 1);
  localparam logic [SEL_W:0]   c_num_moves   = (SEL_W + 1)'(NUM_MOVES);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [15:0]        w_lfsr;
  logic               w_unused_lfsr;
  logic [ACC_W-1:0]   w_roll;

  logic [SEL_W-1:0]   r_move;
  logic               r_no_pp_lat;
  logic               r_illegal_lat;

  logic               w_accept;
  logic               w_req_legal;
  logic               w_req_no_pp;
  logic [PP_W-1:0]    w_pp_req;
  logic [PP_W-1:0]    w_pp [NUM_MOVES];

  logic [DMG_W-1:0]   w_dmg_tab [NUM_MOVES];
  logic [ACC_W-1:0]   w_acc_tab [NUM_MOVES];
  logic [DMG_W-1:0]   w_sel_dmg;
  logic [ACC_W-1:0]   w_sel_acc;
  logic               w_hit_calc;

  logic               r_res_hit;
  logic [DMG_W-1:0]   r_res_dmg;
  logic               r_res_no_pp;
  logic               r_res_illegal;

  pbs_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .value (w_lfsr)
  );

  assign w_roll        = w_lfsr[ACC_W-1:0];
  assign w_unused_lfsr = ^w_lfsr;

  generate
    for (genvar gi = 0; gi < NUM_MOVES; gi++) begin : g_table
      assign w_dmg_tab[gi] = DMG_W'(move_dmg(gi));
      assign w_acc_tab[gi] = ACC_W'(move_acc(gi));
    end
  endgenerate

  assign w_accept    = (r_state == ST_IDLE) && req_valid;
  assign w_req_legal = ({1'b0, req_move} < c_num_moves);

  always_comb begin
    w_pp_req = '0;
    for (int i = 0; i < NUM_MOVES; i++) begin
      if (req_move == SEL_W'(i)) w_pp_req = w_pp[i];
    end
  end

  // A coincident refill means the counter is effectively full at acceptance
  assign w_req_no_pp = w_req_legal && !pp_refill && (w_pp_req == '0);

  generate
    for (genvar gp = 0; gp < NUM_MOVES; gp++) begin : g_pp
      logic            r_cnt;
      logic [PP_W-1:0] r_pp;
      logic            w_take;

      assign w_take = w_accept && w_req_legal && (req_move == SEL_W'(gp));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pp <= c_pp_init;
        end else if (pp_refill) begin
          r_pp <= w_take ? c_pp_init_m1 : c_pp_init;
        end else if (w_take && (r_pp != '0)) begin
          r_pp <= r_pp - 1'b1;
        end
      end

      assign r_cnt    = 1'b0;
      assign w_pp[gp] = r_pp;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_move        <= '0;
      r_no_pp_lat   <= 1'b0;
      r_illegal_lat <= 1'b0;
    end else if (w_accept) begin
      r_move        <= req_move;
      r_no_pp_lat   <= w_req_no_pp;
      r_illegal_lat <= !w_req_legal;
    end
  end

  always_comb begin
    w_sel_dmg = '0;
    w_sel_acc = '0;
    for (int i = 0; i < NUM_MOVES; i++) begin
      if (r_move == SEL_W'(i)) begin
        w_sel_dmg = w_dmg_tab[i];
        w_sel_acc = w_acc_tab[i];
      end
    end
  end

  assign w_hit_calc = !r_illegal_lat && !r_no_pp_lat && (w_roll < w_sel_acc);

  // Result registers load on the ROLL cycle and hold through RESULT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_hit     <= 1'b0;
      r_res_dmg     <= '0;
      r_res_no_pp   <= 1'b0;
      r_res_illegal <= 1'b0;
    end else if (r_state == ST_ROLL) begin
      r_res_hit     <= w_hit_calc;
      r_res_dmg     <= w_hit_calc ? w_sel_dmg : '0;
      r_res_no_pp   <= r_no_pp_lat;
      r_res_illegal <= r_illegal_lat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (req_valid) w_state_nxt = ST_ROLL;
      ST_ROLL:   w_state_nxt = ST_RESULT;
      ST_RESULT: if (res_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign req_ready   = (r_state == ST_IDLE);
  assign res_valid   = (r_state == ST_RESULT);
  assign res_hit     = r_res_hit;
  assign res_dmg     = r_res_dmg;
  assign res_no_pp   = r_res_no_pp;
  assign res_illegal = r_res_illegal;

endmodule
`default_nettype wire

// File: tb/tb_move_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_move_resolver                                            |
// | Brief  : Directed self-checking bench for move_resolver              |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_move_resolver;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [1:0] req_move;
  logic       pp_refill;
  logic       res_ready;
  logic       use3;

  logic       rdy4, rv4, hit4, np4, il4;
  logic [3:0] dmg4;
  logic       rdy3, rv3, hit3, np3, il3;
  logic [3:0] dmg3;

  logic       req_ready, res_valid, res_hit, res_no_pp, res_illegal;
  logic [3:0] res_dmg;

  int checks;
  int failures;

  logic [15:0] m_lfsr;
  logic        cap_hit, cap_np, cap_il;
  logic [3:0]  cap_dmg, cap_roll;

  localparam logic [3:0][3:0] c_acc = {4'd3, 4'd7, 4'd8, 4'd10};
  localparam logic [3:0][3:0] c_dmg = {4'd11, 4'd5, 4'd3, 4'd1};

  move_resolver dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid & ~use3),
    .req_move    (req_move),
    .req_ready   (rdy4),
    .pp_refill   (pp_refill & ~use3),
    .res_valid   (rv4),
    .res_ready   (res_ready),
    .res_hit     (hit4),
    .res_dmg     (dmg4),
    .res_no_pp   (np4),
    .res_illegal (il4)
  );

  move_resolver #(.NUM_MOVES(3), .SEL_W(2)) dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid & use3),
    .req_move    (req_move),
    .req_ready   (rdy3),
    .pp_refill   (pp_refill & use3),
    .res_valid   (rv3),
    .res_ready   (res_ready),
    .res_hit     (hit3),
    .res_dmg     (dmg3),
    .res_no_pp   (np3),
    .res_illegal (il3)
  );

  assign req_ready   = use3 ? rdy3 : rdy4;
  assign res_valid   = use3 ? rv3  : rv4;
  assign res_hit     = use3 ? hit3 : hit4;
  assign res_dmg     = use3 ? dmg3 : dmg4;
  assign res_no_pp   = use3 ? np3  : np4;
  assign res_illegal = use3 ? il3  : il4;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference LFSR: x^16+x^14+x^13+x^11+1, right-shifting, seed ACE1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end

  // One full transaction with res_ready high; called and returns on a negedge
  task automatic xact(input logic [1:0] mv, input logic refill);
    int n;
    n = 0;
    while (!req_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL xact_ready_timeout got=%0b want=1", req_ready);
    end
    req_valid = 1'b1;
    req_move  = mv;
    pp_refill = refill;
    res_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    pp_refill = 1'b0;
    cap_roll  = m_lfsr[3:0];
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1) begin
      failures++;
      $display("FAIL xact_latency res_valid=%0b want=1", res_valid);
    end
    cap_hit = res_hit;
    cap_dmg = res_dmg;
    cap_np  = res_no_pp;
    cap_il  = res_illegal;
    @(negedge clk);
  endtask

  task automatic test_reset();
    use3 = 1'b0; req_valid = 1'b0; req_move = 2'd0; pp_refill = 1'b0; res_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, res_valid, res_hit, res_dmg, res_no_pp, res_illegal} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%0b v=%0b hit=%0b dmg=%0d np=%0b il=%0b want 1 0 0 0 0 0",
               req_ready, res_valid, res_hit, res_dmg, res_no_pp, res_illegal);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got rdy=%0b v=%0b want 1 0", req_ready, res_valid);
    end
  endtask

  task automatic test_pp_exhaust();
    for (int i = 0; i < 6; i++) begin
      xact(2'd0, 1'b0);
      checks++;
      if (i < 5) begin
        if (cap_np !== 1'b0 || cap_hit !== (cap_roll < 4'd10) || cap_dmg !== ((cap_roll < 4'd10) ? 4'd1 : 4'd0)) begin
          failures++;
          $display("FAIL exhaust_%0d got np=%0b hit=%0b dmg=%0d roll=%0d want np=0 hit=%0b", i, cap_np, cap_hit, cap_dmg, cap_roll, cap_roll < 4'd10);
        end
      end else if (cap_np !== 1'b1 || cap_hit !== 1'b0 || cap_dmg !== 4'd0) begin
        failures++;
        $display("FAIL exhaust_sixth got np=%0b hit=%0b dmg=%0d want np=1 hit=0 dmg=0", cap_np, cap_hit, cap_dmg);
      end
    end
  endtask

  task automatic test_hold();
    logic       h_hit;
    logic [3:0] h_dmg;
    logic       exp_hit;
    req_valid = 1'b1; req_move = 2'd3; res_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    cap_roll  = m_lfsr[3:0];
    checks++;
    if (res_valid !== 1'b0 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL hold_roll_state got v=%0b rdy=%0b want 0 0", res_valid, req_ready);
    end
    @(negedge clk);
    exp_hit = (cap_roll < 4'd3);
    h_hit = res_hit;
    h_dmg = res_dmg;
    checks++;
    if (res_valid !== 1'b1 || h_hit !== exp_hit || h_dmg !== (exp_hit ? 4'd11 : 4'd0) || res_no_pp !== 1'b0) begin
      failures++;
      $display("FAIL hold_result got v=%0b hit=%0b dmg=%0d np=%0b want 1 %0b %0d 0", res_valid, h_hit, h_dmg, res_no_pp, exp_hit, exp_hit ? 11 : 0);
    end
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_move = 2'd0;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || req_ready !== 1'b0 || res_hit !== h_hit || res_dmg !== h_dmg) begin
        failures++;
        $display("FAIL hold_stable_%0d got v=%0b rdy=%0b hit=%0b dmg=%0d want 1 0 %0b %0d", i, res_valid, req_ready, res_hit, res_dmg, h_hit, h_dmg);
      end
    end
    req_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release got v=%0b rdy=%0b want 0 1", res_valid, req_ready);
    end
  endtask

  task automatic test_refill_coincident();
    for (int i = 0; i < 6; i++) begin
      xact(2'd1, 1'b0);
      checks++;
      if (cap_np !== (i == 5)) begin
        failures++;
        $display("FAIL drain1_%0d got np=%0b want %0b", i, cap_np, i == 5);
      end
    end
    xact(2'd1, 1'b1);
    checks++;
    if (cap_np !== 1'b0 || cap_hit !== (cap_roll < 4'd8) || cap_dmg !== ((cap_roll < 4'd8) ? 4'd3 : 4'd0)) begin
      failures++;
      $display("FAIL refill_coincident got np=%0b hit=%0b dmg=%0d want np=0 hit=%0b", cap_np, cap_hit, cap_dmg, cap_roll < 4'd8);
    end
    for (int i = 0; i < 5; i++) begin
      xact(2'd1, 1'b0);
      checks++;
      if (cap_np !== (i == 4)) begin
        failures++;
        $display("FAIL after_refill_%0d got np=%0b want %0b", i, cap_np, i == 4);
      end
    end
  endtask

  task automatic test_illegal();
    use3 = 1'b1;
    @(negedge clk);
    xact(2'd3, 1'b0);
    checks++;
    if (cap_il !== 1'b1 || cap_hit !== 1'b0 || cap_dmg !== 4'd0 || cap_np !== 1'b0) begin
      failures++;
      $display("FAIL illegal got il=%0b hit=%0b dmg=%0d np=%0b want 1 0 0 0", cap_il, cap_hit, cap_dmg, cap_np);
    end
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < 6; i++) begin
        xact(2'(m), 1'b0);
        checks++;
        if (cap_np !== (i == 5) || cap_il !== 1'b0) begin
          failures++;
          $display("FAIL illegal_pp_m%0d_%0d got np=%0b il=%0b want %0b 0", m, i, cap_np, cap_il, i == 5);
        end
      end
    end
    use3 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lfsr_stream();
    logic       exp_hit;
    logic [3:0] exp_dmg;
    for (int i = 0; i < 1000; i++) begin
      xact(2'd0, (i % 4) == 0);
      exp_hit = (cap_roll < 4'd10);
      exp_dmg = exp_hit ? 4'd1 : 4'd0;
      checks++;
      if (cap_hit !== exp_hit || cap_dmg !== exp_dmg || cap_np !== 1'b0) begin
        failures++;
        $display("FAIL stream_%0d got hit=%0b dmg=%0d np=%0b want %0b %0d 0 roll=%0d", i, cap_hit, cap_dmg, cap_np, exp_hit, exp_dmg, cap_roll);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic exp_hit;
    req_valid = 1'b1; req_move = 2'd2; res_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre got v=%0b want 1", res_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1 || res_hit !== 1'b0 || res_dmg !== 4'd0) begin
      failures++;
      $display("FAIL midreset_async got v=%0b rdy=%0b hit=%0b dmg=%0d want 0 1 0 0", res_valid, req_ready, res_hit, res_dmg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_ready got %0b want 1", req_ready);
    end
    for (int i = 0; i < 6; i++) begin
      xact(2'd2, 1'b0);
      exp_hit = (i < 5) && (cap_roll < 4'd7);
      checks++;
      if (cap_np !== (i == 5) || cap_hit !== exp_hit || cap_dmg !== (exp_hit ? 4'd5 : 4'd0)) begin
        failures++;
        $display("FAIL midreset_m2_%0d got np=%0b hit=%0b dmg=%0d want %0b %0b roll=%0d", i, cap_np, cap_hit, cap_dmg, i == 5, exp_hit, cap_roll);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_pp_exhaust();
    test_hold();
    test_refill_coincident();
    test_illegal();
    test_lfsr_stream();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
